// File: rtl/pixel_word_packer_pkg.sv
// Shared pixel and FSM definitions for the pixel
// processing blocks.
package pixel_word_packer_pkg;

    localparam int PIXEL_SIZE = 24;
    localparam int COLOR_SIZE = 8;
    localparam int COUNT_W    = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pixel_word_packer_if.sv
// Frame control, pixel stream and packed word bundle
// for pixel_word_packer.
interface pixel_word_packer_if #(
    parameter int DATA_WIDTH = 32
);
    import pixel_word_packer_pkg::*;

    logic                  start;
    logic [COUNT_W-1:0]    pix_count;
    logic [PIXEL_SIZE-1:0] pixel_in;
    logic                  pixel_vld;
    logic                  pixel_rdy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  vld;
    logic                  last_data;
    logic                  done;

    modport master (
        output start,
        output pix_count,
        output pixel_in,
        output pixel_vld,
        input  pixel_rdy,
        input  data_out,
        input  vld,
        input  last_data,
        input  done
    );

    modport slave (
        input  start,
        input  pix_count,
        input  pixel_in,
        input  pixel_vld,
        output pixel_rdy,
        output data_out,
        output vld,
        output last_data,
        output done
    );

endinterface

// File: rtl/pixel_word_packer.sv
// Packs 24-bit RGB pixels LSB-first into DATA_WIDTH
// words as a continuous bit stream, one frame per start.
module pixel_word_packer
    import pixel_word_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    pixel_word_packer_if.slave  bus
);

    localparam int BW = DATA_WIDTH + PIXEL_SIZE;
    localparam int FW = $clog2(BW + 1);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("pixel_word_packer: DATA_WIDTH must be 32 or 64");
    end

    state_e             state;
    state_e             state_n;
    logic [COUNT_W-1:0] remaining;
    logic [BW-1:0]      pbuf;
    logic [FW-1:0]      fill;

    logic               xfer;
    logic               emit;
    logic               last_word;
    logic [BW-1:0]      shifted;
    logic [BW-1:0]      pix_ext;
    logic [FW-1:0]      fill_after;

    assign bus.pixel_rdy = (state == S_RUN) && (remaining != '0);
    assign xfer          = bus.pixel_vld && bus.pixel_rdy;

    // FLUSH drains full words first; the final partial word
    // leaves the buffer with zeros above fill as padding.
    assign last_word = (state == S_FLUSH) && (fill != '0)
                    && (fill <= FW'(DATA_WIDTH));
    assign emit = ((state == S_RUN) && (fill >= FW'(DATA_WIDTH)))
               || ((state == S_FLUSH) && (fill != '0));

    assign pix_ext = {{DATA_WIDTH{1'b0}}, bus.pixel_in};
    assign shifted = emit ? (pbuf >> DATA_WIDTH) : pbuf;

    always_comb begin
        fill_after = fill;
        if (last_word) begin
            fill_after = '0;
        end else if (emit) begin
            fill_after = fill - FW'(DATA_WIDTH);
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = (bus.pix_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer && remaining == COUNT_W'(1)) begin
                    state_n = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (last_word) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            pbuf      <= '0;
            fill      <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && bus.start) begin
                remaining <= bus.pix_count;
                pbuf      <= '0;
                fill      <= '0;
            end else if (xfer) begin
                remaining <= remaining - COUNT_W'(1);
                pbuf      <= shifted | (pix_ext << fill_after);
                fill      <= fill_after + FW'(PIXEL_SIZE);
            end else begin
                pbuf      <= shifted;
                fill      <= fill_after;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out  <= '0;
            bus.vld       <= 1'b0;
            bus.last_data <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.vld       <= emit;
            bus.last_data <= last_word;
            bus.done      <= (state == S_DONE);
            if (emit) begin
                bus.data_out <= pbuf[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Drives 32- and 64-bit packers with identical pixel streams
// and compares their words against a bit-stream model.
module tb_pixel_word_packer;
    import pixel_word_packer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pix_count = '0;
    logic [23:0] pixel_in = '0;
    logic        pixel_vld = 1'b0;

    always #5 clk = ~clk;

    pixel_word_packer_if #(.DATA_WIDTH(32)) b32 ();
    pixel_word_packer_if #(.DATA_WIDTH(64)) b64 ();

    assign b32.start = start;
    assign b32.pix_count = pix_count;
    assign b32.pixel_in = pixel_in;
    assign b32.pixel_vld = pixel_vld;
    assign b64.start = start;
    assign b64.pix_count = pix_count;
    assign b64.pixel_in = pixel_in;
    assign b64.pixel_vld = pixel_vld;

    pixel_word_packer #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(b32.slave));
    pixel_word_packer #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .bus(b64.slave));

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] w32_q[$];
    logic [63:0] w64_q[$];
    bit          l32_q[$];
    bit          l64_q[$];
    int d32_n = 0, d64_n = 0, d32_c = 0, d64_c = 0;
    int l32_c = 0, l64_c = 0, rdy_n = 0;

    always @(negedge clk) begin
        if (b32.vld) begin
            w32_q.push_back(64'(b32.data_out));
            l32_q.push_back(b32.last_data);
            if (b32.last_data) l32_c = cyc;
        end
        if (b64.vld) begin
            w64_q.push_back(b64.data_out);
            l64_q.push_back(b64.last_data);
            if (b64.last_data) l64_c = cyc;
        end
        if (b32.done) begin d32_n++; d32_c = cyc; end
        if (b64.done) begin d64_n++; d64_c = cyc; end
        if (b32.pixel_rdy || b64.pixel_rdy) rdy_n++;
    end

    logic [23:0] exp_pix[$];
    int feed_idx = 0;
    int start_cyc = 0;
    int s_w32, s_w64, s_d32, s_d64, s_rdy;

    // Word k of the stream: bit b is pixel b/24, bit b%24.
    function automatic logic [63:0] model_word(int dw, int k);
        logic [63:0] w = '0;
        logic [23:0] p;
        int s;
        for (int b = 0; b < dw; b++) begin
            s = k * dw + b;
            if (s < 24 * exp_pix.size()) begin
                p = exp_pix[s / 24];
                w[b] = p[s % 24];
            end
        end
        return w;
    endfunction

    function automatic int dwid(int d);
        return d ? 64 : 32;
    endfunction
    function automatic int exp_n(int d);
        return (24 * exp_pix.size() + dwid(d) - 1) / dwid(d);
    endfunction
    function automatic int got_n(int d);
        return d ? w64_q.size() - s_w64 : w32_q.size() - s_w32;
    endfunction
    function automatic logic [63:0] got_w(int d, int k);
        return d ? w64_q[s_w64 + k] : w32_q[s_w32 + k];
    endfunction
    function automatic bit got_l(int d, int k);
        return d ? l64_q[s_w64 + k] : l32_q[s_w32 + k];
    endfunction
    function automatic int done_n(int d);
        return d ? d64_n - s_d64 : d32_n - s_d32;
    endfunction

    task automatic snap();
        s_w32 = w32_q.size();
        s_w64 = w64_q.size();
        s_d32 = d32_n;
        s_d64 = d64_n;
        s_rdy = rdy_n;
    endtask

    task automatic start_frame(input int n);
        snap();
        feed_idx = 0;
        @(negedge clk);
        start = 1'b1;
        pix_count = 16'(n);
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // gap: 0 none, 1 alternate, 2 random; poke pulses start
    // after that many pixels have been accepted.
    task automatic feed(input int cnt, input int gap,
                        input int poke, output bit ok);
        int sent = 0;
        int guard = 0;
        bit v, r;
        bit tog = 1'b0;
        bit poked = 1'b0;
        while (sent < cnt && guard < 1000) begin
            @(negedge clk);
            guard++;
            v = (gap == 0) ? 1'b1 :
                (gap == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            pixel_in = exp_pix[feed_idx];
            pixel_vld = v;
            if (poke >= 0 && sent == poke && !poked) begin
                start = 1'b1;
                pix_count = 16'd3;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            r = b32.pixel_rdy;
            @(posedge clk);
            if (v && r) begin
                sent++;
                feed_idx++;
            end
        end
        @(negedge clk);
        pixel_vld = 1'b0;
        start = 1'b0;
        ok = (sent == cnt);
    endtask

    task automatic wait_done(output bit ok);
        int guard = 0;
        while ((done_n(0) < 1 || done_n(1) < 1) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        ok = (done_n(0) >= 1 && done_n(1) >= 1);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({b32.data_out, b32.vld, b32.last_data, b32.done,
             b32.pixel_rdy} !== '0) begin
            errors++;
            $display("FAIL reset32 got %h want 0", b32.data_out);
        end
        checks++;
        if ({b64.data_out, b64.vld, b64.last_data, b64.done,
             b64.pixel_rdy} !== '0) begin
            errors++;
            $display("FAIL reset64 got %h want 0", b64.data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input string nm, input int n,
                             input int gap, input int poke);
        bit ok;
        start_frame(n);
        if (n > 0) begin
            feed(n, gap, poke, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s feed_timeout got 0 want 1", nm);
            end
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s done_timeout got 0 want 1", nm);
        end
    endtask

    task automatic test_basic();
        logic [31:0] want[3];
        want = '{32'h66112233, 32'h88994455, 32'hAABBCC77};
        exp_pix = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        run_frame("basic", 4, 0, -1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_n(d) !== exp_n(d)) begin
                errors++;
                $display("FAIL basic_count dw=%0d got %0d want %0d",
                         dwid(d), got_n(d), exp_n(d));
            end
            for (int k = 0; k < got_n(d) && k < exp_n(d); k++) begin
                checks++;
                if (got_w(d, k) !== model_word(dwid(d), k)) begin
                    errors++;
                    $display("FAIL basic_word dw=%0d k=%0d got %h want %h",
                             dwid(d), k, got_w(d, k),
                             model_word(dwid(d), k));
                end
                checks++;
                if (got_l(d, k) !== (k == exp_n(d) - 1)) begin
                    errors++;
                    $display("FAIL basic_last dw=%0d k=%0d got %0b",
                             dwid(d), k, got_l(d, k));
                end
            end
            checks++;
            if (done_n(d) !== 1) begin
                errors++;
                $display("FAIL basic_done dw=%0d got %0d want 1",
                         dwid(d), done_n(d));
            end
        end
        for (int k = 0; k < 3 && k < got_n(0); k++) begin
            checks++;
            if (got_w(0, k) !== 64'(want[k])) begin
                errors++;
                $display("FAIL basic_const k=%0d got %h want %h",
                         k, got_w(0, k), want[k]);
            end
        end
        checks++;
        if (d32_c !== l32_c + 1) begin
            errors++;
            $display("FAIL done_after_last got %0d want %0d",
                     d32_c, l32_c + 1);
        end
        checks++;
        if (b32.data_out !== want[2]) begin
            errors++;
            $display("FAIL hold_data got %h want %h",
                     b32.data_out, want[2]);
        end
    endtask

    task automatic test_single();
        exp_pix = '{24'hABCDEF};
        run_frame("single", 1, 0, -1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_n(d) !== 1) begin
                errors++;
                $display("FAIL single_count dw=%0d got %0d want 1",
                         dwid(d), got_n(d));
            end else begin
                checks++;
                if (got_w(d, 0) !== 64'h0000_0000_00AB_CDEF
                    || got_l(d, 0) !== 1'b1) begin
                    errors++;
                    $display("FAIL single_word dw=%0d got %h/%0b want 00abcdef/1",
                             dwid(d), got_w(d, 0), got_l(d, 0));
                end
            end
            checks++;
            if (done_n(d) !== 1) begin
                errors++;
                $display("FAIL single_done dw=%0d got %0d want 1",
                         dwid(d), done_n(d));
            end
        end
    endtask

    task automatic test_zero();
        exp_pix = {};
        run_frame("zero", 0, 0, -1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_n(d) !== 0 || done_n(d) !== 1) begin
                errors++;
                $display("FAIL zero_frame dw=%0d got words %0d done %0d want 0/1",
                         dwid(d), got_n(d), done_n(d));
            end
        end
        checks++;
        if (d32_c !== start_cyc + 2 || d64_c !== start_cyc + 2) begin
            errors++;
            $display("FAIL zero_latency got %0d/%0d want %0d",
                     d32_c, d64_c, start_cyc + 2);
        end
        checks++;
        if (rdy_n !== s_rdy) begin
            errors++;
            $display("FAIL zero_rdy got %0d want %0d", rdy_n, s_rdy);
        end
    endtask

    task automatic test_frames(input string nm, input int n,
                               input int gap, input int poke);
        exp_pix = {};
        for (int i = 0; i < n; i++) exp_pix.push_back(24'($urandom));
        run_frame(nm, n, gap, poke);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_n(d) !== exp_n(d)) begin
                errors++;
                $display("FAIL %s_count dw=%0d n=%0d got %0d want %0d",
                         nm, dwid(d), n, got_n(d), exp_n(d));
            end
            for (int k = 0; k < got_n(d) && k < exp_n(d); k++) begin
                checks++;
                if (got_w(d, k) !== model_word(dwid(d), k)) begin
                    errors++;
                    $display("FAIL %s_word dw=%0d k=%0d got %h want %h",
                             nm, dwid(d), k, got_w(d, k),
                             model_word(dwid(d), k));
                end
                checks++;
                if (got_l(d, k) !== (k == exp_n(d) - 1)) begin
                    errors++;
                    $display("FAIL %s_last dw=%0d k=%0d got %0b",
                             nm, dwid(d), k, got_l(d, k));
                end
            end
            checks++;
            if (done_n(d) !== 1) begin
                errors++;
                $display("FAIL %s_done dw=%0d got %0d want 1",
                         nm, dwid(d), done_n(d));
            end
        end
    endtask

    task automatic test_gaps();
        test_frames("gaps", 8, 1, -1);
    endtask

    task automatic test_start_in_run();
        test_frames("start_in_run", 6, 0, 2);
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            test_frames("random", $urandom_range(1, 20), 2, -1);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        exp_pix = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        start_frame(4);
        feed(2, 0, -1, ok);
        @(negedge clk);
        checks++;
        if (b32.vld !== 1'b1 || b32.data_out !== 32'h66112233) begin
            errors++;
            $display("FAIL mid_first_word got %0b/%h want 1/66112233",
                     b32.vld, b32.data_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b32.data_out, b32.vld, b32.last_data, b32.done,
             b32.pixel_rdy, b64.data_out, b64.vld, b64.last_data,
             b64.done, b64.pixel_rdy} !== '0) begin
            errors++;
            $display("FAIL mid_reset got %h/%h want 0/0",
                     b32.data_out, b64.data_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (done_n(0) !== 0 || done_n(1) !== 0 || l32_q[$] !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done got %0d/%0d want 0/0",
                     done_n(0), done_n(1));
        end
        run_frame("after_reset", 4, 0, -1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got_n(d) !== exp_n(d)) begin
                errors++;
                $display("FAIL after_reset_count dw=%0d got %0d want %0d",
                         dwid(d), got_n(d), exp_n(d));
            end
            for (int k = 0; k < got_n(d) && k < exp_n(d); k++) begin
                checks++;
                if (got_w(d, k) !== model_word(dwid(d), k)
                    || got_l(d, k) !== (k == exp_n(d) - 1)) begin
                    errors++;
                    $display("FAIL after_reset_word dw=%0d k=%0d got %h want %h",
                             dwid(d), k, got_w(d, k),
                             model_word(dwid(d), k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_zero();
        test_gaps();
        test_start_in_run();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_word_packer.md
PIXEL_WORD_PACKER -- requirements
Module: pixel_word_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, output word width; legal values 32 or 64.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin a frame; sampled only in IDLE.
REQ-005 SHALL have port pix_count, input, 16, number of pixels in the frame; latched when start is accepted.
REQ-006 SHALL have port pixel_in, input, 24, RGB pixel: {B[23:16], G[15:8], R[7:0]}.
REQ-007 SHALL have port pixel_vld, input, 1, pixel_in is valid.
REQ-008 SHALL have port pixel_rdy, output, 1, packer accepts pixel_in this cycle; transfer = pixel_vld && pixel_rdy.
REQ-009 SHALL have port data_out, output, DATA_WIDTH, packed word to the downstream processor.
REQ-010 SHALL have port vld, output, 1, data_out valid; one-cycle pulse per word; downstream has no backpressure.
REQ-011 SHALL have port last_data, output, 1, high with vld on the final word of the frame only.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when the frame is complete.

Function
REQ-013 SHALL pack pixels LSB-first as a continuous bit stream: pixel i occupies stream bits [24i+23:24i], and word k is stream bits [DATA_WIDTH*k+DATA_WIDTH-1:DATA_WIDTH*k]; pixels straddle word boundaries.
REQ-014 SHALL implement FSM states IDLE, RUN, FLUSH, DONE.
REQ-015 SHALL go IDLE->RUN on start when pix_count != 0, latching remaining = pix_count and clearing the bit buffer.
REQ-016 SHALL go IDLE->DONE on start when pix_count == 0; no vld is emitted.
REQ-017 SHALL drive pixel_rdy = (state == RUN) && (remaining != 0), combinationally from registered state.
REQ-018 SHALL hold a bit buffer of DATA_WIDTH+24 bits plus a fill counter (bits held, 0..DATA_WIDTH+23).
REQ-019 SHALL, on each transfer, append pixel_in at bit position fill and decrement remaining.
REQ-020 SHALL, in any cycle with fill >= DATA_WIDTH, register the low DATA_WIDTH buffer bits onto data_out with vld = 1 on the next cycle and shift the buffer down by DATA_WIDTH; append and emit may occur in the same cycle and are applied as emit-then-append.
REQ-021 SHALL go RUN->FLUSH on the cycle the last pixel is accepted.
REQ-022 SHALL in FLUSH emit remaining full words, then, if 0 < fill < DATA_WIDTH, emit one final word zero-padded in the upper bits.
REQ-023 SHALL assert last_data with the word after which fill == 0 in FLUSH; a frame ending exactly on a word boundary emits no pad word.
REQ-024 SHALL go FLUSH->DONE on the cycle the last word is emitted; DONE pulses done for one cycle, then returns to IDLE.
REQ-025 SHALL ignore start in RUN, FLUSH and DONE.
REQ-026 SHALL emit exactly ceil(24*pix_count/DATA_WIDTH) words per frame.
REQ-027 SHALL hold data_out at its last value when vld is low.
REQ-028 SHALL tolerate arbitrary pixel_vld gaps; word content depends only on pixel order.

Reset
REQ-029 SHALL on rst_n low asynchronously force state IDLE, buffer, fill and remaining to 0, and data_out = 0, vld = 0, last_data = 0, done = 0, pixel_rdy = 0.
REQ-030 SHALL, on reset mid-frame, discard partial data with no last_data or done; the next start begins a clean frame.

Structure
REQ-031 SHALL take PIXEL_SIZE (24), COLOR_SIZE (8) and the FSM state enum from a shared package used by the processor blocks.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 DW=32, N=4, pixels 112233, 445566, 778899, AABBCC -> words 66112233, 88994455, AABBCC77; last_data on the third; done one cycle after it.
REQ-034 DW=32, N=1, pixel ABCDEF -> single word 00ABCDEF with vld and last_data, then done.
REQ-035 N=0 start -> done pulse two cycles after start, no vld, pixel_rdy never high.
REQ-036 DW=64, N=8 with pixel_vld toggling every other cycle -> exactly 3 words, contents equal to the gap-free run, last_data only on word 3.
REQ-037 start pulsed during RUN -> ignored; frame completes unchanged; no second done.
REQ-038 rst_n low after 2 of 4 pixels -> all outputs 0 immediately; new N=4 frame reproduces REQ-033 words.
